fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the FIFO write port (wdata, wclk_en) among NREQ requesters in the wclk domain.
- Grants one requester at a time for a burst of up to BURST_MAX words.
- Honours wfull from the write-pointer/full logic, so no word is lost or duplicated.
- Sits between write-side client blocks and the FIFO memory + write-pointer logic.

---
 rtl/fifo_arb_pkg.sv | 40 ++++
 rtl/fifo_wr_arbiter_rr_picker.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizing and small helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Default sizing of the arbiter; instances may override via parameters.
    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_BURST_MAX = 4;
    localparam int DEF_STALL_W   = 16;

    // Widest requester vector the helpers below are sized for.
    localparam int MAX_NREQ = 8;

    // Derived widths for the default configuration.
    localparam int DEF_IDX_W  = $clog2(DEF_NREQ);
    localparam int DEF_BCNT_W = $clog2(DEF_BURST_MAX + 1);

    // One-hot "nobody granted" pattern.
    localparam logic [MAX_NREQ-1:0] ONEHOT_NONE = 8'h00;

    // Index of the set bit of a one-hot (or zero) vector; zero maps to 0.
    function automatic int onehot_index(input logic [MAX_NREQ-1:0] vec);
        int idx;
        idx = 32'sd0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            idx = vec[i] ? i : idx;
        end
        return idx;
    endfunction

    // Increment an index modulo n.
    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after 'start',
// wrapping, found by rotating, priority-encoding and rotating back.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  pick,
    output logic             found
);

    logic [NREQ-1:0]  rot_s;
    logic [IDX_W-1:0] pos_s;
    int               back_s;

    // Rotate so that 'start' lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_s  = '0;
        pos_s  = '0;
        back_s = 32'sd0;
        pick   = '0;
        found  = |req;
        for (int i = 0; i < NREQ; i++) begin
            rot_s[i] = req[IDX_W'(((i + int'(start)) >= NREQ) ? (i + int'(start) - NREQ)
                                                                : (i + int'(start)))];
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            pos_s = rot_s[i] ? IDX_W'(i) : pos_s;
        end
        back_s = int'(pos_s) + int'(start);
        back_s = (back_s >= NREQ) ? (back_s - NREQ) : back_s;
        for (int i = 0; i < NREQ; i++) begin
            pick[i] = found && (back_s == i);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ write-side clients.
// A grant lasts for up to BURST_MAX words; wfull stalls the granted client
// without losing or duplicating a word.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int NREQ      = DEF_NREQ,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int STALL_W   = DEF_STALL_W
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATA_SIZE-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wfull,
    output logic [DATA_SIZE-1:0]      wdata,
    output logic                      wclk_en,
    output logic [NREQ-1:0]           grant,
    output logic [STALL_W-1:0]        stall_cnt
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int BCNT_W = $clog2(BURST_MAX + 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0]  LAST_RST   = IDX_W'(NREQ - 1);

    arb_state_e         state_r, state_s;
    logic [NREQ-1:0]    grant_r, grant_s;
    logic [IDX_W-1:0]   last_r, last_s;
    logic [BCNT_W-1:0]  burst_cnt_r, burst_cnt_s;
    logic [STALL_W-1:0] stall_cnt_r, stall_cnt_s;

    logic               busy_s;
    logic               valid_g_s;
    logic               release_s;
    logic [IDX_W-1:0]   g_idx_s;
    logic [IDX_W-1:0]   start_s;
    logic [NREQ-1:0]    pick_s;
    logic               found_s;

    assign grant     = grant_r;
    assign stall_cnt = stall_cnt_r;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req_valid),
        .start (start_s),
        .pick  (pick_s),
        .found (found_s)
    );

    // Decode the current grant and decide where the next round-robin search starts.
    always_comb begin
        busy_s    = (state_r == BUSY);
        valid_g_s = |(req_valid & grant_r);
        g_idx_s   = IDX_W'(onehot_index(MAX_NREQ'(grant_r)));
        if (busy_s) begin
            start_s = IDX_W'(wrap_inc(int'(g_idx_s), NREQ));
        end else begin
            start_s = IDX_W'(wrap_inc(int'(last_r), NREQ));
        end
    end

    // Write-port outputs follow the registered grant; nothing is written in a reset cycle.
    always_comb begin
        req_ready = '0;
        wclk_en   = 1'b0;
        wdata     = '0;
        if (busy_s && !wrst) begin
            req_ready = wfull ? '0 : grant_r;
            wclk_en   = valid_g_s && !wfull;
        end else begin
            req_ready = '0;
            wclk_en   = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            wdata = wdata | (req_data[i*DATA_SIZE +: DATA_SIZE] & {DATA_SIZE{grant_r[i]}});
        end
    end

    // A grant ends after its last burst word or when its client drops valid.
    always_comb begin
        release_s = busy_s && (!valid_g_s || (wclk_en && (burst_cnt_r == BURST_LAST)));
    end

    // Next-state logic: grant hand-over without bubbles, stall accounting.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        last_s      = last_r;
        burst_cnt_s = burst_cnt_r;
        stall_cnt_s = stall_cnt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s = BUSY;
                    grant_s = pick_s;
                end else begin
                    state_s = IDLE;
                    grant_s = '0;
                end
            end
            BUSY: begin
                if (release_s) begin
                    last_s      = g_idx_s;
                    burst_cnt_s = '0;
                    if (found_s) begin
                        state_s = BUSY;
                        grant_s = pick_s;
                    end else begin
                        state_s = IDLE;
                        grant_s = '0;
                    end
                end else if (wclk_en) begin
                    burst_cnt_s = burst_cnt_r + BCNT_W'(1);
                end else begin
                    burst_cnt_s = burst_cnt_r;
                end
            end
            default: begin
                state_s     = IDLE;
                grant_s     = '0;
                last_s      = LAST_RST;
                burst_cnt_s = '0;
            end
        endcase
        if (busy_s && valid_g_s && wfull) begin
            stall_cnt_s = (&stall_cnt_r) ? stall_cnt_r : (stall_cnt_r + STALL_W'(1));
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // State registers with synchronous reset; requester 0 gets first priority after reset.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_r     <= IDLE;
            grant_r     <= ONEHOT_NONE[NREQ-1:0];
            last_r      <= LAST_RST;
            burst_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            last_r      <= last_s;
            burst_cnt_r <= burst_cnt_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a random run,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int BM   = 4;
    localparam int SW   = 4;
    localparam int SMAX = 15;

    logic              wclk = 1'b0;
    logic              wrst = 1'b1;
    logic              wfull = 1'b0;
    logic [NR-1:0]     req_valid = 4'b0000;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     wdata;
    logic              wclk_en;
    logic [NR-1:0]     grant;
    logic [SW-1:0]     stall_cnt;

    wire  [20:0]       obs_v = {grant, req_ready, wclk_en, wdata, stall_cnt};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who holds the port, round-robin pointer, burst and stall counts.
    bit         m_busy;
    int         m_g;
    int         m_last;
    int         m_burst;
    int         m_stall;
    logic [3:0] m_acc;
    logic [7:0] nxt [NR];
    int         wcount [NR];
    bit         rand_data = 1'b0;

    logic [3:0] exp_grant, exp_ready;
    logic       exp_en;
    logic [7:0] exp_wdata;
    logic [20:0] exp_v;

    fifo_wr_arbiter #(
        .DATA_SIZE (DW),
        .NREQ      (NR),
        .BURST_MAX (BM),
        .STALL_W   (SW)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .wdata     (wdata),
        .wclk_en   (wclk_en),
        .grant     (grant),
        .stall_cnt (stall_cnt)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pick_from(input logic [3:0] v, input int start);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (start + k) % NR;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic init_data();
        for (int i = 0; i < NR; i++) begin
            nxt[i]    = rand_data ? 8'($urandom) : (8'h11 + 8'(32 * i));
            wcount[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = nxt[i];
    endtask

    task automatic model_outputs();
        exp_grant = m_busy ? (4'b0001 << m_g[1:0]) : 4'b0000;
        exp_en    = m_busy && !wrst && req_valid[m_g[1:0]] && !wfull;
        exp_ready = (m_busy && !wrst && !wfull) ? exp_grant : 4'b0000;
        exp_wdata = m_busy ? nxt[m_g[1:0]] : 8'h00;
        exp_v     = {exp_grant, exp_ready, exp_en, exp_wdata, 4'(m_stall)};
    endtask

    task automatic model_step();
        int  p;
        bit  v, x;
        m_acc = 4'b0000;
        if (wrst) begin
            m_busy = 1'b0; m_g = -1; m_last = NR - 1; m_burst = 0; m_stall = 0;
        end else if (!m_busy) begin
            p = pick_from(req_valid, (m_last + 1) % NR);
            if (p >= 0) begin m_busy = 1'b1; m_g = p; end
        end else begin
            v = req_valid[m_g[1:0]];
            x = v && !wfull;
            if (v && wfull && m_stall < SMAX) m_stall++;
            if (x) begin
                m_acc[m_g[1:0]] = 1'b1;
                wcount[m_g]++;
                nxt[m_g] = rand_data ? 8'($urandom) : (nxt[m_g] + 8'd1);
            end
            if (!v || (x && m_burst == BM - 1)) begin
                m_last  = m_g;
                m_burst = 0;
                p = pick_from(req_valid, (m_g + 1) % NR);
                if (p >= 0) m_g = p;
                else begin m_busy = 1'b0; m_g = -1; end
            end else if (x) begin
                m_burst++;
            end
        end
    endtask

    task automatic settle();
        @(negedge wclk);
        model_outputs();
    endtask

    task automatic advance();
        model_step();
        @(posedge wclk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        wrst = 1'b1; wfull = 1'b0; req_valid = 4'b0000;
        init_data(); drive();
        settle(); advance();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        wrst = 1'b1;
        settle(); advance();
        settle();
        n_checks++;
        if (obs_v !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs_v, 21'h0);
        end
        n_checks++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_model: got %h want %h", obs_v, exp_v);
        end
        advance();
        wrst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] wlog[$];
        do_reset();
        req_valid = 4'b0001;
        for (int c = 1; c <= 7; c++) begin
            settle();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL single_model c%0d: got %h want %h", c, obs_v, exp_v);
            end
            n_checks++;
            if ({grant, wclk_en} !== ((c >= 2) ? 5'b00011 : 5'b00000)) begin
                n_fail++;
                $display("FAIL single_timing c%0d: got grant=%b en=%b", c, grant, wclk_en);
            end
            if (wclk_en) wlog.push_back(wdata);
            advance();
        end
        n_checks++;
        if (wlog.size() != 6) begin
            n_fail++;
            $display("FAIL single_count: got %0d want 6", wlog.size());
        end
        for (int k = 0; k < wlog.size(); k++) begin
            n_checks++;
            if (wlog[k] !== 8'h11 + 8'(k)) begin
                n_fail++;
                $display("FAIL single_data %0d: got %h want %h", k, wlog[k], 8'h11 + 8'(k));
            end
        end
        req_valid = 4'b0000;
        settle(); advance();
    endtask

    task automatic test_round_robin();
        logic [3:0] glog[$];
        logic [3:0] prev;
        int         dcnt [NR];
        logic [3:0] gexp [5];
        gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = 4'b0000;
        for (int i = 0; i < NR; i++) dcnt[i] = 0;
        do_reset();
        req_valid = 4'b1111;
        for (int c = 1; c <= 18; c++) begin
            settle();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL rr_model c%0d: got %h want %h", c, obs_v, exp_v);
            end
            if (c >= 2) begin
                n_checks++;
                if (wclk_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_no_bubble c%0d: got en=%b want 1", c, wclk_en);
                end
            end
            if (grant !== prev && grant !== 4'b0000) glog.push_back(grant);
            prev = grant;
            for (int i = 0; i < NR; i++) if (wclk_en && grant[i]) dcnt[i]++;
            advance();
        end
        n_checks++;
        if (glog.size() != 5) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d want 5", glog.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (glog[k] !== gexp[k]) begin
                    n_fail++;
                    $display("FAIL rr_grant_seq %0d: got %b want %b", k, glog[k], gexp[k]);
                end
            end
        end
        n_checks++;
        if (dcnt[0] != 5 || dcnt[1] != 4 || dcnt[2] != 4 || dcnt[3] != 4) begin
            n_fail++;
            $display("FAIL rr_writes: got %0d %0d %0d %0d want 5 4 4 4",
                     dcnt[0], dcnt[1], dcnt[2], dcnt[3]);
        end
        req_valid = 4'b0000;
        settle(); advance();
    endtask

    task automatic test_stall();
        int d1;
        d1 = 0;
        do_reset();
        req_valid = 4'b1010;
        for (int c = 1; c <= 12; c++) begin
            wfull = (c >= 4 && c <= 8);
            settle();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL stall_model c%0d: got %h want %h", c, obs_v, exp_v);
            end
            if (wfull) begin
                n_checks++;
                if (wclk_en !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: got en=%b ready=%b grant=%b", c, wclk_en, req_ready, grant);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (stall_cnt !== 4'd5) begin
                    n_fail++;
                    $display("FAIL stall_count: got %0d want 5", stall_cnt);
                end
            end
            if (c == 11) begin
                n_checks++;
                if (grant !== 4'b1000 || d1 != 4) begin
                    n_fail++;
                    $display("FAIL stall_burst: got grant=%b req1_writes=%0d want 1000 4", grant, d1);
                end
            end
            if (wclk_en && grant[1]) d1++;
            advance();
        end
        wfull = 1'b0; req_valid = 4'b0000;
        settle(); advance();
    endtask

    task automatic test_drop();
        int d2;
        d2 = 0;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            req_valid = (c <= 3) ? 4'b1100 : 4'b1000;
            settle();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL drop_model c%0d: got %h want %h", c, obs_v, exp_v);
            end
            if (c == 4 || c == 5) begin
                n_checks++;
                if (grant !== ((c == 4) ? 4'b0100 : 4'b1000)) begin
                    n_fail++;
                    $display("FAIL drop_grant c%0d: got %b", c, grant);
                end
            end
            if (wclk_en && grant[2]) d2++;
            advance();
        end
        n_checks++;
        if (d2 != 2) begin
            n_fail++;
            $display("FAIL drop_writes: got %0d want 2", d2);
        end
        req_valid = 4'b0000;
        settle(); advance();
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        do_reset();
        req_valid = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            wfull = (c == 3);
            settle();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL rstmid_model c%0d: got %h want %h", c, obs_v, exp_v);
            end
            if (grant == 4'b1000 && wclk_en) begin
                hit = 1'b1;
                advance();
                break;
            end
            advance();
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rstmid_timeout: req3 never written within 30 cycles");
        end
        wfull = 1'b0;
        wrst  = 1'b1;
        settle();
        n_checks++;
        if (wclk_en !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_nowrite: got en=%b ready=%b want 0", wclk_en, req_ready);
        end
        advance();
        wrst = 1'b0;
        settle();
        n_checks++;
        if ({grant, req_ready, wclk_en, stall_cnt} !== 13'h0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: got grant=%b ready=%b en=%b stall=%0d",
                     grant, req_ready, wclk_en, stall_cnt);
        end
        advance();
        settle();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_first: got %b want 0001", grant);
        end
        n_checks++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL rstmid_after: got %h want %h", obs_v, exp_v);
        end
        advance();
        req_valid = 4'b0000;
        settle(); advance();
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 4'b0001;
        wfull = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            settle();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL sat_model c%0d: got %h want %h", c, obs_v, exp_v);
            end
            advance();
        end
        settle();
        n_checks++;
        if (stall_cnt !== 4'd15 || wclk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_value: got stall=%0d en=%b want 15 0", stall_cnt, wclk_en);
        end
        advance();
        wfull = 1'b0; req_valid = 4'b0000;
        settle(); advance();
    endtask

    task automatic test_random();
        int dut_writes, model_before, model_after;
        dut_writes = 0;
        rand_data = 1'b1;
        do_reset();
        model_before = 0;
        for (int c = 0; c < 300; c++) begin
            wfull = ($urandom_range(3) == 0);
            settle();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL rand_model c%0d: got %h want %h", c, obs_v, exp_v);
            end
            n_checks++;
            if ((wclk_en && wfull) || !$onehot0(grant)) begin
                n_fail++;
                $display("FAIL rand_invariant c%0d: got en=%b full=%b grant=%b", c, wclk_en, wfull, grant);
            end
            if (wclk_en) dut_writes++;
            advance();
            for (int i = 0; i < NR; i++) begin
                if (m_acc[i]) req_valid[i] = ($urandom_range(1) == 1);
                else if (req_valid[i]) req_valid[i] = ($urandom_range(9) != 0);
                else req_valid[i] = ($urandom_range(2) == 0);
            end
        end
        model_after = wcount[0] + wcount[1] + wcount[2] + wcount[3];
        n_checks++;
        if (dut_writes != model_after - model_before || dut_writes == 0) begin
            n_fail++;
            $display("FAIL rand_total: got %0d want %0d", dut_writes, model_after - model_before);
        end
        rand_data = 1'b0;
        req_valid = 4'b0000; wfull = 1'b0;
        settle(); advance();
    endtask

    initial begin
        m_busy = 1'b0; m_g = -1; m_last = NR - 1; m_burst = 0; m_stall = 0; m_acc = 4'b0000;
        init_data();
        drive();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_drop();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
